// File: rtl/flow_rule_matcher_if.sv
`default_nettype none
// ============================================================================
//  Module  : flow_rule_matcher_if
//  Brief   : Verdict channel from the flow rule matcher to the forwarding
//            stage (valid/ready handshake with status, rule index, action).
//  Rev     : 1.0  initial release
// ============================================================================
interface flow_rule_matcher_if #(
    parameter int IDX_W = 3
);
    logic             res_valid;
    logic             res_ready;
    logic [1:0]       res_status;
    logic [IDX_W-1:0] res_rule_idx;
    logic             res_action;

    // Matcher side: produces the verdict, observes ready.
    modport master (
        output res_valid,
        output res_status,
        output res_rule_idx,
        output res_action,
        input  res_ready
    );

    // Forwarding-stage side: consumes the verdict.
    modport slave (
        input  res_valid,
        input  res_status,
        input  res_rule_idx,
        input  res_action,
        output res_ready
    );
endinterface
`default_nettype wire

// File: rtl/flow_rule_matcher.sv
`default_nettype none
// ============================================================================
//  Module  : flow_rule_matcher
//  Brief   : Captures a parsed IPv4 5-tuple and walks a programmable rule
//            table one entry per cycle, lowest index first, returning the
//            first-match action. Bad packets bypass the search.
//  Rev     : 1.0  initial release
// ============================================================================
module flow_rule_matcher #(
    parameter int   NUM_RULES      = 8,
    parameter int   IDX_W          = $clog2(NUM_RULES),
    parameter logic DEFAULT_ACTION = 1'b1
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    // parsed packet tuple
    input  wire logic [31:0]       src_ip,
    input  wire logic [31:0]       dst_ip,
    input  wire logic [15:0]       src_port,
    input  wire logic [15:0]       dst_port,
    input  wire logic              is_tcp,
    input  wire logic              is_udp,
    input  wire logic              checksum_ok,
    input  wire logic              parser_done,
    input  wire logic              parser_error,
    // rule table programming
    input  wire logic              cfg_we,
    input  wire logic [IDX_W-1:0]  cfg_idx,
    input  wire logic              cfg_en,
    input  wire logic [31:0]       cfg_src_ip,
    input  wire logic [31:0]       cfg_src_mask,
    input  wire logic [31:0]       cfg_dst_ip,
    input  wire logic [31:0]       cfg_dst_mask,
    input  wire logic              cfg_port_any,
    input  wire logic [15:0]       cfg_port_lo,
    input  wire logic [15:0]       cfg_port_hi,
    input  wire logic [1:0]        cfg_proto,
    input  wire logic              cfg_action,
    // verdict channel
    flow_rule_matcher_if.master    res,
    // status
    output logic                   busy,
    output logic [15:0]            drop_cnt
);

    localparam logic [1:0]       C_ST_MISS     = 2'd0;
    localparam logic [1:0]       C_ST_HIT      = 2'd1;
    localparam logic [1:0]       C_ST_BAD      = 2'd2;
    localparam logic [1:0]       C_PROTO_ANY   = 2'd0;
    localparam logic [1:0]       C_PROTO_TCP   = 2'd1;
    localparam logic [1:0]       C_PROTO_UDP   = 2'd2;
    localparam logic [IDX_W-1:0] C_LAST_IDX    = IDX_W'(NUM_RULES - 1);
    localparam logic [31:0]      C_NUM_RULES_U = 32'(NUM_RULES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // rule table
    logic        r_rule_en     [NUM_RULES];
    logic [31:0] r_rule_src_ip [NUM_RULES];
    logic [31:0] r_rule_src_msk[NUM_RULES];
    logic [31:0] r_rule_dst_ip [NUM_RULES];
    logic [31:0] r_rule_dst_msk[NUM_RULES];
    logic        r_rule_any    [NUM_RULES];
    logic [15:0] r_rule_lo     [NUM_RULES];
    logic [15:0] r_rule_hi     [NUM_RULES];
    logic [1:0]  r_rule_proto  [NUM_RULES];
    logic        r_rule_action [NUM_RULES];

    // latched tuple
    logic [31:0] r_src_ip;
    logic [31:0] r_dst_ip;
    logic [15:0] r_dst_port;
    logic        r_is_tcp;
    logic        r_is_udp;

    // search pointer and verdict
    logic [IDX_W-1:0] r_idx;
    logic [1:0]       r_status;
    logic [IDX_W-1:0] r_rule_idx;
    logic             r_action;
    logic [15:0]      r_drop_cnt;

    logic [IDX_W-1:0] w_idx_nxt;
    logic [1:0]       w_status_nxt;
    logic [IDX_W-1:0] w_rule_idx_nxt;
    logic             w_action_nxt;
    logic             w_load;

    logic w_capture;
    logic w_drop;
    logic w_bad;
    logic w_cfg_in_range;
    logic w_proto_ok;
    logic w_port_ok;
    logic w_addr_ok;
    logic w_rule_hit;
    logic w_unused_src_port;

    // The L4 source port is part of the parser tuple but plays no role in matching.
    assign w_unused_src_port = ^src_port;

    // A new packet is taken when idle, or when the pending verdict is consumed.
    assign w_capture      = parser_done &&
                            ((r_state == S_IDLE) || ((r_state == S_RESULT) && res.res_ready));
    assign w_drop         = parser_done && !w_capture;
    assign w_bad          = parser_error || !checksum_ok;
    assign w_cfg_in_range = ({{(32-IDX_W){1'b0}}, cfg_idx} < C_NUM_RULES_U);

    // Evaluate the entry under the search pointer against the latched tuple.
    always_comb begin
        w_proto_ok = 1'b0;
        case (r_rule_proto[r_idx])
            C_PROTO_ANY: w_proto_ok = 1'b1;
            C_PROTO_TCP: w_proto_ok = r_is_tcp;
            C_PROTO_UDP: w_proto_ok = r_is_udp;
            default:     w_proto_ok = 1'b0;
        endcase
        // An inverted range (lo > hi) can never satisfy both bounds.
        w_port_ok  = r_rule_any[r_idx] ||
                     ((r_is_tcp || r_is_udp) &&
                      (r_dst_port >= r_rule_lo[r_idx]) &&
                      (r_dst_port <= r_rule_hi[r_idx]));
        w_addr_ok  = (((r_src_ip ^ r_rule_src_ip[r_idx]) & r_rule_src_msk[r_idx]) == 32'd0) &&
                     (((r_dst_ip ^ r_rule_dst_ip[r_idx]) & r_rule_dst_msk[r_idx]) == 32'd0);
        w_rule_hit = r_rule_en[r_idx] && w_addr_ok && w_proto_ok && w_port_ok;
    end

    // Next-state and verdict selection; a capture overrides everything else.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_status_nxt   = r_status;
        w_rule_idx_nxt = r_rule_idx;
        w_action_nxt   = r_action;
        w_load         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_IDLE;
            end
            S_SEARCH: begin
                if (w_rule_hit) begin
                    w_state_nxt    = S_RESULT;
                    w_status_nxt   = C_ST_HIT;
                    w_rule_idx_nxt = r_idx;
                    w_action_nxt   = r_rule_action[r_idx];
                end else if (r_idx == C_LAST_IDX) begin
                    w_state_nxt    = S_RESULT;
                    w_status_nxt   = C_ST_MISS;
                    w_rule_idx_nxt = '0;
                    w_action_nxt   = DEFAULT_ACTION;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            S_RESULT: begin
                if (res.res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_capture) begin
            w_load    = 1'b1;
            w_idx_nxt = '0;
            if (w_bad) begin
                w_state_nxt    = S_RESULT;
                w_status_nxt   = C_ST_BAD;
                w_rule_idx_nxt = '0;
                w_action_nxt   = 1'b0;
            end else begin
                w_state_nxt = S_SEARCH;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tuple latch, search pointer and verdict registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src_ip   <= '0;
            r_dst_ip   <= '0;
            r_dst_port <= '0;
            r_is_tcp   <= 1'b0;
            r_is_udp   <= 1'b0;
            r_idx      <= '0;
            r_status   <= C_ST_MISS;
            r_rule_idx <= '0;
            r_action   <= 1'b0;
        end else begin
            if (w_load) begin
                r_src_ip   <= src_ip;
                r_dst_ip   <= dst_ip;
                r_dst_port <= dst_port;
                r_is_tcp   <= is_tcp;
                r_is_udp   <= is_udp;
            end
            r_idx      <= w_idx_nxt;
            r_status   <= w_status_nxt;
            r_rule_idx <= w_rule_idx_nxt;
            r_action   <= w_action_nxt;
        end
    end

    // Rule table writes; accepted in any state, out-of-range indices ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                r_rule_en[i]      <= 1'b0;
                r_rule_src_ip[i]  <= '0;
                r_rule_src_msk[i] <= '0;
                r_rule_dst_ip[i]  <= '0;
                r_rule_dst_msk[i] <= '0;
                r_rule_any[i]     <= 1'b0;
                r_rule_lo[i]      <= '0;
                r_rule_hi[i]      <= '0;
                r_rule_proto[i]   <= '0;
                r_rule_action[i]  <= 1'b0;
            end
        end else if (cfg_we && w_cfg_in_range) begin
            r_rule_en[cfg_idx]      <= cfg_en;
            r_rule_src_ip[cfg_idx]  <= cfg_src_ip;
            r_rule_src_msk[cfg_idx] <= cfg_src_mask;
            r_rule_dst_ip[cfg_idx]  <= cfg_dst_ip;
            r_rule_dst_msk[cfg_idx] <= cfg_dst_mask;
            r_rule_any[cfg_idx]     <= cfg_port_any;
            r_rule_lo[cfg_idx]      <= cfg_port_lo;
            r_rule_hi[cfg_idx]      <= cfg_port_hi;
            r_rule_proto[cfg_idx]   <= cfg_proto;
            r_rule_action[cfg_idx]  <= cfg_action;
        end
    end

    // Saturating count of packets refused because the block was occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign res.res_valid    = (r_state == S_RESULT);
    assign res.res_status   = r_status;
    assign res.res_rule_idx = r_rule_idx;
    assign res.res_action   = r_action;
    assign busy             = (r_state != S_IDLE);
    assign drop_cnt         = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_flow_rule_matcher.sv
`default_nettype none
// ============================================================================
//  Module  : tb_flow_rule_matcher
//  Brief   : Self-checking bench for flow_rule_matcher: directed vector
//            table, hand-written corner sequences and randomized packets
//            checked against a first-match reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_flow_rule_matcher;

    localparam int   NUM_RULES      = 8;
    localparam int   IDX_W          = 3;
    localparam logic DEFAULT_ACTION = 1'b1;

    typedef struct {
        logic        en;
        logic [31:0] sip, smask, dip, dmask;
        logic        any;
        logic [15:0] lo, hi;
        logic [1:0]  proto;
        logic        act;
    } rule_t;

    typedef struct {
        logic [31:0] sip, dip;
        logic [15:0] sport, dport;
        logic        tcp, udp, cks, err;
    } pkt_t;

    typedef struct {
        logic [1:0] st;
        int         idx;
        logic       act;
        int         lat;
    } exp_t;

    typedef struct {
        pkt_t p;
        exp_t e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] src_ip = '0, dst_ip = '0;
    logic [15:0] src_port = '0, dst_port = '0;
    logic is_tcp = 0, is_udp = 0, checksum_ok = 0, parser_done = 0, parser_error = 0;
    logic cfg_we = 0, cfg_en = 0, cfg_port_any = 0, cfg_action = 0;
    logic [IDX_W-1:0] cfg_idx = '0;
    logic [31:0] cfg_src_ip = '0, cfg_src_mask = '0, cfg_dst_ip = '0, cfg_dst_mask = '0;
    logic [15:0] cfg_port_lo = '0, cfg_port_hi = '0;
    logic [1:0]  cfg_proto = '0;
    logic        busy;
    logic [15:0] drop_cnt;

    int errors = 0;
    int checks = 0;

    rule_t mrule[NUM_RULES];

    flow_rule_matcher_if #(.IDX_W(IDX_W)) res_if ();

    flow_rule_matcher #(
        .NUM_RULES     (NUM_RULES),
        .DEFAULT_ACTION(DEFAULT_ACTION)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .src_ip       (src_ip),
        .dst_ip       (dst_ip),
        .src_port     (src_port),
        .dst_port     (dst_port),
        .is_tcp       (is_tcp),
        .is_udp       (is_udp),
        .checksum_ok  (checksum_ok),
        .parser_done  (parser_done),
        .parser_error (parser_error),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_en       (cfg_en),
        .cfg_src_ip   (cfg_src_ip),
        .cfg_src_mask (cfg_src_mask),
        .cfg_dst_ip   (cfg_dst_ip),
        .cfg_dst_mask (cfg_dst_mask),
        .cfg_port_any (cfg_port_any),
        .cfg_port_lo  (cfg_port_lo),
        .cfg_port_hi  (cfg_port_hi),
        .cfg_proto    (cfg_proto),
        .cfg_action   (cfg_action),
        .res          (res_if),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rule_t mk_rule(logic en, logic [31:0] sip, logic [31:0] smask,
                                      logic [31:0] dip, logic [31:0] dmask, logic any,
                                      logic [15:0] lo, logic [15:0] hi, logic [1:0] proto,
                                      logic act);
        rule_t r;
        r.en = en; r.sip = sip; r.smask = smask; r.dip = dip; r.dmask = dmask;
        r.any = any; r.lo = lo; r.hi = hi; r.proto = proto; r.act = act;
        return r;
    endfunction

    function automatic pkt_t mk_pkt(logic [31:0] sip, logic [31:0] dip, logic [15:0] dport,
                                    logic tcp, logic udp, logic cks, logic err);
        pkt_t p;
        p.sip = sip; p.dip = dip; p.sport = 16'h1234; p.dport = dport;
        p.tcp = tcp; p.udp = udp; p.cks = cks; p.err = err;
        return p;
    endfunction

    function automatic exp_t mk_exp(logic [1:0] st, int idx, logic act, int lat);
        exp_t e;
        e.st = st; e.idx = idx; e.act = act; e.lat = lat;
        return e;
    endfunction

    // Reference: scan the table in priority order and return the first match.
    function automatic logic rule_matches(rule_t r, pkt_t p);
        logic addr, proto, port;
        addr  = ((p.sip & r.smask) == (r.sip & r.smask)) &&
                ((p.dip & r.dmask) == (r.dip & r.dmask));
        proto = (r.proto == 2'd0) || (r.proto == 2'd1 && p.tcp) || (r.proto == 2'd2 && p.udp);
        port  = r.any || ((p.tcp || p.udp) && p.dport >= r.lo && p.dport <= r.hi);
        return r.en && addr && proto && port;
    endfunction

    function automatic exp_t model(pkt_t p);
        if (p.err || !p.cks) return mk_exp(2'd2, 0, 1'b0, 1);
        for (int i = 0; i < NUM_RULES; i++) begin
            if (rule_matches(mrule[i], p)) return mk_exp(2'd1, i, mrule[i].act, i + 2);
        end
        return mk_exp(2'd0, 0, DEFAULT_ACTION, NUM_RULES + 1);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_RULES; i++)
            mrule[i] = mk_rule(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg_write(int idx, rule_t r);
        cfg_idx = IDX_W'(idx); cfg_en = r.en; cfg_src_ip = r.sip; cfg_src_mask = r.smask;
        cfg_dst_ip = r.dip; cfg_dst_mask = r.dmask; cfg_port_any = r.any;
        cfg_port_lo = r.lo; cfg_port_hi = r.hi; cfg_proto = r.proto; cfg_action = r.act;
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        if (idx < NUM_RULES) mrule[idx] = r;
    endtask

    task automatic drive_pkt(pkt_t p);
        src_ip = p.sip; dst_ip = p.dip; src_port = p.sport; dst_port = p.dport;
        is_tcp = p.tcp; is_udp = p.udp; checksum_ok = p.cks; parser_error = p.err;
        parser_done = 1'b1;
    endtask

    // Cycles after the capture edge until res_valid; 0 means the bound expired.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            if (res_if.res_valid) begin
                lat = n;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic send_and_check(string tag, pkt_t p, exp_t e);
        int lat;
        drive_pkt(p);
        @(posedge clk); #1;
        parser_done = 1'b0;
        wait_valid(lat);
        check({tag, " latency"}, lat, e.lat);
        check({tag, " status"}, {30'd0, res_if.res_status}, {30'd0, e.st});
        check({tag, " rule_idx"}, {29'd0, res_if.res_rule_idx}, e.idx);
        check({tag, " action"}, {31'd0, res_if.res_action}, {31'd0, e.act});
        res_if.res_ready = 1'b1;
        @(posedge clk); #1;
        res_if.res_ready = 1'b0;
        check({tag, " valid after handshake"}, {31'd0, res_if.res_valid}, 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        int lat;
        exp_t e;
        pkt_t p;

        res_if.res_ready = 1'b0;
        model_clear();

        // Directed vectors against the fixed table programmed below.
        vecs[0].p  = mk_pkt(32'h0A010203, 32'h0,        16'd80, 1, 0, 1, 0); vecs[0].e  = mk_exp(2'd1, 0, 0, 2);
        vecs[1].p  = mk_pkt(32'h01020304, 32'hC0A80001, 16'd53, 0, 1, 1, 0); vecs[1].e  = mk_exp(2'd1, 3, 1, 5);
        vecs[2].p  = mk_pkt(32'h01020304, 32'hC0A80001, 16'd54, 0, 1, 1, 0); vecs[2].e  = mk_exp(2'd0, 0, 1, 9);
        vecs[3].p  = mk_pkt(32'h0A010203, 32'h0,        16'd80, 1, 0, 0, 0); vecs[3].e  = mk_exp(2'd2, 0, 0, 1);
        vecs[4].p  = mk_pkt(32'h0A010203, 32'h0,        16'd80, 1, 0, 1, 1); vecs[4].e  = mk_exp(2'd2, 0, 0, 1);
        vecs[5].p  = mk_pkt(32'h0B000001, 32'h0,        16'd80, 0, 0, 1, 0); vecs[5].e  = mk_exp(2'd0, 0, 1, 9);
        vecs[6].p  = mk_pkt(32'h0C000001, 32'h0,        16'd80, 0, 0, 1, 0); vecs[6].e  = mk_exp(2'd1, 5, 0, 7);
        vecs[7].p  = mk_pkt(32'h0B000001, 32'h0,        16'd0,  1, 0, 1, 0); vecs[7].e  = mk_exp(2'd1, 4, 0, 6);
        vecs[8].p  = mk_pkt(32'h0A000001, 32'h0,        16'd7,  0, 1, 1, 0); vecs[8].e  = mk_exp(2'd0, 0, 1, 9);
        vecs[9].p  = mk_pkt(32'h01020304, 32'hC0A80001, 16'd52, 0, 1, 1, 0); vecs[9].e  = mk_exp(2'd0, 0, 1, 9);
        vecs[10].p = mk_pkt(32'h01020304, 32'hC0A80001, 16'd53, 1, 0, 1, 0); vecs[10].e = mk_exp(2'd0, 0, 1, 9);

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset res_valid", {31'd0, res_if.res_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset drop_cnt", {16'd0, drop_cnt}, 32'd0);
        check("reset res_status", {30'd0, res_if.res_status}, 32'd0);
        check("reset res_action", {31'd0, res_if.res_action}, 32'd0);

        // Table: r0 10/8 TCP any; r1 never (proto 11); r2 inverted range;
        // r3 DNS to C0A80001 UDP; r4 11/8 any port range; r5 12/8 port_any.
        cfg_write(0, mk_rule(1, 32'h0A000000, 32'hFF000000, 0, 0, 1, 0, 0, 2'd1, 0));
        cfg_write(1, mk_rule(1, 0, 0, 0, 0, 1, 0, 16'hFFFF, 2'd3, 1));
        cfg_write(2, mk_rule(1, 0, 0, 0, 0, 0, 16'd100, 16'd50, 2'd0, 0));
        cfg_write(3, mk_rule(1, 0, 0, 32'hC0A80001, 32'hFFFFFFFF, 0, 16'd53, 16'd53, 2'd2, 1));
        cfg_write(4, mk_rule(1, 32'h0B000000, 32'hFF000000, 0, 0, 0, 16'd0, 16'hFFFF, 2'd0, 0));
        cfg_write(5, mk_rule(1, 32'h0C000000, 32'hFF000000, 0, 0, 1, 0, 0, 2'd0, 0));

        for (int i = 0; i < 11; i++)
            send_and_check($sformatf("vec%0d", i), vecs[i].p, vecs[i].e);

        // Held verdict: three refused packets, fields must not move.
        drive_pkt(vecs[1].p);
        @(posedge clk); #1;
        parser_done = 1'b0;
        wait_valid(lat);
        check("hold latency", lat, 5);
        for (int k = 0; k < 3; k++) begin
            drive_pkt(vecs[0].p);
            @(posedge clk); #1;
            parser_done = 1'b0;
            @(posedge clk); #1;
        end
        check("hold drop_cnt", {16'd0, drop_cnt}, 32'd3);
        check("hold valid", {31'd0, res_if.res_valid}, 32'd1);
        check("hold status", {30'd0, res_if.res_status}, 32'd1);
        check("hold rule_idx", {29'd0, res_if.res_rule_idx}, 32'd3);
        check("hold action", {31'd0, res_if.res_action}, 32'd1);
        // Handshake and capture of a BAD packet in the same cycle.
        drive_pkt(vecs[3].p);
        res_if.res_ready = 1'b1;
        @(posedge clk); #1;
        parser_done = 1'b0;
        res_if.res_ready = 1'b0;
        check("b2b valid", {31'd0, res_if.res_valid}, 32'd1);
        check("b2b status", {30'd0, res_if.res_status}, 32'd2);
        check("b2b rule_idx", {29'd0, res_if.res_rule_idx}, 32'd0);
        check("b2b action", {31'd0, res_if.res_action}, 32'd0);
        check("b2b drop_cnt", {16'd0, drop_cnt}, 32'd3);
        res_if.res_ready = 1'b1;
        @(posedge clk); #1;
        res_if.res_ready = 1'b0;

        // Asynchronous reset in the middle of a search.
        drive_pkt(vecs[2].p);
        @(posedge clk); #1;
        parser_done = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset valid", {31'd0, res_if.res_valid}, 32'd0);
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset drop_cnt", {16'd0, drop_cnt}, 32'd0);
        model_clear();
        @(posedge clk); #1 rst_n = 1'b1;
        e = model(vecs[0].p);
        check("post-reset model is miss", {30'd0, e.st}, 32'd0);
        send_and_check("post-reset", vecs[0].p, e);

        // Randomized table contents and packets against the reference model.
        for (int it = 0; it < 60; it++) begin
            logic [31:0] ips [4];
            logic [31:0] msk [4];
            int mode;
            ips[0] = 32'h0A000001; ips[1] = 32'h0A000102; ips[2] = 32'hC0A80001; ips[3] = 32'h0B000001;
            msk[0] = 32'h0;        msk[1] = 32'hFF000000; msk[2] = 32'hFFFFFF00; msk[3] = 32'hFFFFFFFF;
            if ($urandom_range(0, 1) == 0 || it < 8) begin
                cfg_write($urandom_range(0, NUM_RULES - 1),
                          mk_rule($urandom_range(0, 3) != 0,
                                  ips[$urandom_range(0, 3)], msk[$urandom_range(0, 3)],
                                  ips[$urandom_range(0, 3)], msk[$urandom_range(0, 3)],
                                  $urandom_range(0, 2) == 0,
                                  16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
                                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))));
            end
            mode = $urandom_range(0, 2);
            p = mk_pkt(ips[$urandom_range(0, 3)], ips[$urandom_range(0, 3)],
                       16'($urandom_range(0, 15)), mode == 1, mode == 2,
                       $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
            send_and_check($sformatf("rand%0d", it), p, model(p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
